// File: rtl/ff_conv_pkg.sv
// Shared mode and FSM-state encodings for the multi-mode flip-flop bank.
package ff_conv_pkg;

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_SR = 2'b10,
        MODE_JK = 2'b11
    } mode_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SWITCH = 1'b1
    } state_t;

endpackage

// File: rtl/ff_conv_bank_if.sv
// Control/data bundle of the flip-flop bank; master drives inputs, slave is the bank.
interface ff_conv_bank_if
    import ff_conv_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) ();

    logic             en;
    mode_t            mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic             busy;
    mode_t            act_mode;
    logic [WIDTH-1:0] err;

    modport master (
        output en, mode, a, b, err_clr,
        input  q, qn, busy, act_mode, err
    );

    modport slave (
        input  en, mode, a, b, err_clr,
        output q, qn, busy, act_mode, err
    );

endinterface

// File: rtl/ff_conv_cell.sv
// Single-bit next-state logic for a D/T/SR/JK flip-flop plus SR-illegal detect.
module ff_conv_cell
    import ff_conv_pkg::*;
#(
    parameter bit SR_HOLD = 1'b1
) (
    input  mode_t mode,
    input  logic  a,
    input  logic  b,
    input  logic  q,
    output logic  q_nxt,
    output logic  illegal
);

    always_comb begin
        q_nxt   = q;
        illegal = 1'b0;
        case (mode)
            MODE_D: q_nxt = a;
            MODE_T: q_nxt = q ^ a;
            MODE_SR: begin
                illegal = a & b;
                case ({a, b})
                    2'b10:   q_nxt = 1'b1;
                    2'b01:   q_nxt = 1'b0;
                    2'b11:   q_nxt = SR_HOLD ? q : 1'b0;
                    default: q_nxt = q;
                endcase
            end
            MODE_JK: begin
                case ({a, b})
                    2'b10:   q_nxt = 1'b1;
                    2'b01:   q_nxt = 1'b0;
                    2'b11:   q_nxt = ~q;
                    default: q_nxt = q;
                endcase
            end
            default: q_nxt = q;
        endcase
    end

endmodule

// File: rtl/ff_conv_bank.sv
// WIDTH-channel flip-flop bank with runtime D/T/SR/JK mode, guarded two-edge
// mode switching, update enable and sticky per-channel SR-illegal flags.
module ff_conv_bank
    import ff_conv_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SR_HOLD   = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    ff_conv_bank_if.slave  bus
);

    state_t           state;
    mode_t            pend;
    mode_t            act_mode;
    logic             busy;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] err;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] illegal;
    logic [WIDTH-1:0] err_set;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_conv_cell #(
            .SR_HOLD (SR_HOLD)
        ) u_cell (
            .mode    (act_mode),
            .a       (bus.a[i]),
            .b       (bus.b[i]),
            .q       (q[i]),
            .q_nxt   (q_nxt[i]),
            .illegal (illegal[i])
        );
    end

    // Flags track the active mode even on the edge that detects a pending switch.
    always_comb begin
        err_set = '0;
        if (state == ST_RUN && bus.en && act_mode == MODE_SR) begin
            err_set = illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            pend     <= MODE_D;
            act_mode <= MODE_D;
            busy     <= 1'b0;
            q        <= RESET_VAL;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.mode != act_mode) begin
                        pend  <= bus.mode;
                        busy  <= 1'b1;
                        state <= ST_SWITCH;
                    end else if (bus.en) begin
                        q <= q_nxt;
                    end
                end
                ST_SWITCH: begin
                    act_mode <= pend;
                    busy     <= 1'b0;
                    state    <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= '0;
        end else begin
            err <= (bus.err_clr ? '0 : err) | err_set;
        end
    end

    assign bus.q        = q;
    assign bus.qn       = ~q;
    assign bus.busy     = busy;
    assign bus.act_mode = act_mode;
    assign bus.err      = err;

endmodule

// File: tb/tb_ff_conv_bank.sv
// Bench for ff_conv_bank: two instances (SR_HOLD=1 and 0) fed identical stimulus,
// a directed vector table, hand-written corner sequences and a random run vs a model.
module tb_ff_conv_bank;
    import ff_conv_pkg::*;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    mode_t        mode = MODE_D;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         err_clr = 1'b0;

    int unsigned total = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    ff_conv_bank_if #(.WIDTH(W)) if0 ();
    ff_conv_bank_if #(.WIDTH(W)) if1 ();

    assign if0.en = en;  assign if0.mode = mode;  assign if0.a = a;
    assign if0.b = b;    assign if0.err_clr = err_clr;
    assign if1.en = en;  assign if1.mode = mode;  assign if1.a = a;
    assign if1.b = b;    assign if1.err_clr = err_clr;

    ff_conv_bank #(.WIDTH(W), .RESET_VAL(4'b0000), .SR_HOLD(1'b1)) dut0 (
        .clk (clk), .rst_n (rst_n), .bus (if0.slave)
    );
    ff_conv_bank #(.WIDTH(W), .RESET_VAL(4'b0000), .SR_HOLD(1'b0)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (if1.slave)
    );

    // Reference state: index 0 models SR_HOLD=1, index 1 models SR_HOLD=0.
    logic [W-1:0] m_q   [2];
    logic [W-1:0] m_err [2];
    logic         m_busy[2];
    mode_t        m_act [2];
    mode_t        m_pend[2];

    typedef struct {
        mode_t        mode;
        logic         en;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         clr;
        logic [W-1:0] eq;
        logic         ebusy;
        mode_t        eact;
        logic [W-1:0] eerr;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_q[d] = '0; m_err[d] = '0; m_busy[d] = 1'b0;
            m_act[d] = MODE_D; m_pend[d] = MODE_D;
        end
    endtask

    // Applies the documented per-edge rules to the current inputs.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            logic [W-1:0] set;
            logic [W-1:0] qv;
            qv  = m_q[d];
            set = (!m_busy[d] && en && m_act[d] == MODE_SR) ? (a & b) : '0;
            m_err[d] = (err_clr ? '0 : m_err[d]) | set;
            if (m_busy[d]) begin
                m_act[d] = m_pend[d];
                m_busy[d] = 1'b0;
            end else if (mode != m_act[d]) begin
                m_pend[d] = mode;
                m_busy[d] = 1'b1;
            end else if (en) begin
                case (m_act[d])
                    MODE_D:  m_q[d] = a;
                    MODE_T:  m_q[d] = qv ^ a;
                    MODE_SR: m_q[d] = (d == 0) ? ((a & ~b) | (qv & ~(a ^ b)))
                                               : ((a & ~b) | (qv & ~a & ~b));
                    default: m_q[d] = (a & ~qv) | (~b & qv);
                endcase
            end
        end
    endtask

    task automatic check_model();
        chk("m0_q",    if0.q,              m_q[0]);
        chk("m0_qn",   if0.qn,             ~m_q[0]);
        chk("m0_busy", 4'(if0.busy),       4'(m_busy[0]));
        chk("m0_act",  4'(if0.act_mode),   4'(m_act[0]));
        chk("m0_err",  if0.err,            m_err[0]);
        chk("m1_q",    if1.q,              m_q[1]);
        chk("m1_qn",   if1.qn,             ~m_q[1]);
        chk("m1_busy", 4'(if1.busy),       4'(m_busy[1]));
        chk("m1_act",  4'(if1.act_mode),   4'(m_act[1]));
        chk("m1_err",  if1.err,            m_err[1]);
    endtask

    // Called away from the edge with inputs set; returns at the next negedge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
    endtask

    task automatic set_in(input mode_t m, input logic e, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic c);
        mode = m; en = e; a = av; b = bv; err_clr = c;
    endtask

    // Asynchronous reset pulse between edges; outputs must clear immediately.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, "_q0"},    if0.q,            4'b0000);
        chk({tag, "_qn0"},   if0.qn,           4'b1111);
        chk({tag, "_busy0"}, 4'(if0.busy),     4'b0000);
        chk({tag, "_act0"},  4'(if0.act_mode), 4'(MODE_D));
        chk({tag, "_q1"},    if1.q,            4'b0000);
        chk({tag, "_busy1"}, 4'(if1.busy),     4'b0000);
        chk({tag, "_act1"},  4'(if1.act_mode), 4'(MODE_D));
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{MODE_D,  1'b1, 4'b1010, 4'b0000, 1'b0, 4'b1010, 1'b0, MODE_D,  4'b0000};
        tbl[1]  = '{MODE_D,  1'b0, 4'b0101, 4'b0000, 1'b0, 4'b1010, 1'b0, MODE_D,  4'b0000};
        tbl[2]  = '{MODE_JK, 1'b1, 4'b1111, 4'b1111, 1'b0, 4'b1010, 1'b1, MODE_D,  4'b0000};
        tbl[3]  = '{MODE_JK, 1'b1, 4'b1111, 4'b1111, 1'b0, 4'b1010, 1'b0, MODE_JK, 4'b0000};
        tbl[4]  = '{MODE_JK, 1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0101, 1'b0, MODE_JK, 4'b0000};
        tbl[5]  = '{MODE_JK, 1'b1, 4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0, MODE_JK, 4'b0000};
        tbl[6]  = '{MODE_SR, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, MODE_JK, 4'b0000};
        tbl[7]  = '{MODE_SR, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, MODE_SR, 4'b0000};
        tbl[8]  = '{MODE_SR, 1'b1, 4'b0011, 4'b0101, 1'b0, 4'b0010, 1'b0, MODE_SR, 4'b0001};
        tbl[9]  = '{MODE_SR, 1'b1, 4'b0001, 4'b0001, 1'b1, 4'b0010, 1'b0, MODE_SR, 4'b0001};
        tbl[10] = '{MODE_SR, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b0, MODE_SR, 4'b0000};
        tbl[11] = '{MODE_SR, 1'b1, 4'b0000, 4'b0010, 1'b0, 4'b0000, 1'b0, MODE_SR, 4'b0000};
        tbl[12] = '{MODE_T,  1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, MODE_SR, 4'b0000};
        tbl[13] = '{MODE_T,  1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, MODE_T,  4'b0000};
        tbl[14] = '{MODE_T,  1'b1, 4'b0110, 4'b0000, 1'b0, 4'b0110, 1'b0, MODE_T,  4'b0000};
        tbl[15] = '{MODE_T,  1'b1, 4'b0110, 4'b0000, 1'b0, 4'b0000, 1'b0, MODE_T,  4'b0000};
        tbl[16] = '{MODE_T,  1'b1, 4'b0110, 4'b0000, 1'b0, 4'b0110, 1'b0, MODE_T,  4'b0000};

        model_reset();
        @(negedge clk);
        chk("rst_q",   if0.q,            4'b0000);
        chk("rst_qn",  if0.qn,           4'b1111);
        chk("rst_act", 4'(if0.act_mode), 4'(MODE_D));
        chk("rst_err", if0.err,          4'b0000);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            set_in(tbl[i].mode, tbl[i].en, tbl[i].a, tbl[i].b, tbl[i].clr);
            step();
            chk($sformatf("tbl%0d_q", i),    if0.q,            tbl[i].eq);
            chk($sformatf("tbl%0d_qn", i),   if0.qn,           ~tbl[i].eq);
            chk($sformatf("tbl%0d_busy", i), 4'(if0.busy),     4'(tbl[i].ebusy));
            chk($sformatf("tbl%0d_act", i),  4'(if0.act_mode), 4'(tbl[i].eact));
            chk($sformatf("tbl%0d_err", i),  if0.err,          tbl[i].eerr);
        end

        // Mid-cycle reset with q=0110 in T mode.
        async_reset("mid");
        set_in(MODE_D, 1'b1, 4'b1111, 4'b0000, 1'b0);
        step();

        // SR illegal input: hold instance keeps 1111, clear instance drops to 0000.
        set_in(MODE_SR, 1'b1, 4'b0000, 4'b0000, 1'b0);
        step();
        step();
        set_in(MODE_SR, 1'b1, 4'b1111, 4'b1111, 1'b0);
        step();
        chk("srh0_q1",   if1.q,   4'b0000);
        chk("srh0_err1", if1.err, 4'b1111);
        chk("srh1_q0",   if0.q,   4'b1111);
        chk("srh1_err0", if0.err, 4'b1111);

        // Reset while a switch is pending aborts it.
        set_in(MODE_JK, 1'b1, 4'b0000, 4'b0000, 1'b0);
        step();
        chk("abort_pre_busy", 4'(if0.busy), 4'b0001);
        async_reset("abort");
        set_in(MODE_D, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step();

        // Request changes during SWITCH: first request lands, then a second switch.
        set_in(MODE_T, 1'b1, 4'b0000, 4'b0000, 1'b0);
        step();
        chk("tog_e1_busy", 4'(if0.busy), 4'b0001);
        set_in(MODE_JK, 1'b1, 4'b0000, 4'b0000, 1'b0);
        step();
        chk("tog_e2_act",  4'(if0.act_mode), 4'(MODE_T));
        chk("tog_e2_busy", 4'(if0.busy),     4'b0000);
        step();
        chk("tog_e3_busy", 4'(if0.busy),     4'b0001);
        chk("tog_e3_act",  4'(if0.act_mode), 4'(MODE_T));
        step();
        chk("tog_e4_act",  4'(if0.act_mode), 4'(MODE_JK));
        chk("tog_e4_busy", 4'(if0.busy),     4'b0000);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) mode = mode_t'($urandom_range(0, 3));
            en      = ($urandom_range(0, 3) != 0);
            a       = W'($urandom_range(0, 15));
            b       = W'($urandom_range(0, 15));
            err_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) == 0) async_reset("rnd");
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
